// File: rtl/alu_arb_pkg.sv
// Shared definitions for alu_arbiter: FSM encoding, ALU control codes,
// flag bit positions and the legal-control check.
package alu_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] CTRL_ADD = 3'b000;
    localparam logic [2:0] CTRL_SUB = 3'b001;
    localparam logic [2:0] CTRL_AND = 3'b010;
    localparam logic [2:0] CTRL_OR  = 3'b011;
    localparam logic [2:0] CTRL_SLT = 3'b101;

    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    function automatic logic is_legal_ctrl(input logic [2:0] ctrl);
        logic legal;
        case (ctrl)
            CTRL_ADD, CTRL_SUB, CTRL_AND, CTRL_OR, CTRL_SLT: legal = 1'b1;
            default:                                         legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker. ptr_i names the requester that wins
// a tie; on advance the pointer moves past the winner.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    input  logic       advance_i,
    output logic [1:0] grant_o,
    output logic       ptr_next_o
);

    // One-hot grant: a lone requester always wins, a tie goes to the pointer
    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ptr_i ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

    // Pointer update: favour the loser of the current grant next time
    always_comb begin
        ptr_next_o = ptr_i;
        if (advance_i && grant_o[0]) begin
            ptr_next_o = 1'b1;
        end else if (advance_i && grant_o[1]) begin
            ptr_next_o = 1'b0;
        end else begin
            ptr_next_o = ptr_i;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters, round-robin,
// one operation in flight. Grant counters are built only with ALU_ARB_PERF_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N      = 32,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [N-1:0]      req0_a,
    input  logic [N-1:0]      req0_b,
    input  logic [2:0]        req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [N-1:0]      req1_a,
    input  logic [N-1:0]      req1_b,
    input  logic [2:0]        req1_ctrl,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [N-1:0]      alu_result,
    input  logic              alu_v,
    input  logic              alu_c,
    input  logic              alu_n,
    input  logic              alu_z,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [N-1:0]      rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic [PERF_W-1:0] perf_cnt0,
    output logic [PERF_W-1:0] perf_cnt1
);

    logic [1:0]   state_q, state_d;
    logic         ptr_q, ptr_d;
    logic         owner_q, owner_d;
    logic [N-1:0] op_a_q, op_a_d;
    logic [N-1:0] op_b_q, op_b_d;
    logic [2:0]   op_ctrl_q, op_ctrl_d;
    logic [N-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]   rsp_flags_q, rsp_flags_d;
    logic         rsp_err_q, rsp_err_d;
    logic [1:0]   grant_s;
    logic         accept_s;
    logic         rsp_hs_s;
    logic [3:0]   alu_flags_s;

    assign accept_s = (state_q == ST_IDLE) && (req0_valid || req1_valid);

    rr_arb2 u_rr_arb2 (
        .valid_i    ({req1_valid, req0_valid}),
        .ptr_i      (ptr_q),
        .advance_i  (accept_s),
        .grant_o    (grant_s),
        .ptr_next_o (ptr_d)
    );

    assign req0_ready = (state_q == ST_IDLE) && grant_s[0];
    assign req1_ready = (state_q == ST_IDLE) && grant_s[1];
    assign rsp_hs_s   = (state_q == ST_RESP) && (owner_q ? rsp1_ready : rsp0_ready);

    // Next-state logic; RESP always drops back to IDLE before the next grant
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand and owner capture on the accepting edge
    always_comb begin
        owner_d   = owner_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_ctrl_d = op_ctrl_q;
        if (accept_s && grant_s[1]) begin
            owner_d   = 1'b1;
            op_a_d    = req1_a;
            op_b_d    = req1_b;
            op_ctrl_d = req1_ctrl;
        end else if (accept_s) begin
            owner_d   = 1'b0;
            op_a_d    = req0_a;
            op_b_d    = req0_b;
            op_ctrl_d = req0_ctrl;
        end else begin
            owner_d   = owner_q;
        end
    end

    // Pack the ALU flags into {V,C,N,Z}
    always_comb begin
        alu_flags_s         = 4'b0000;
        alu_flags_s[FLAG_V] = alu_v;
        alu_flags_s[FLAG_C] = alu_c;
        alu_flags_s[FLAG_N] = alu_n;
        alu_flags_s[FLAG_Z] = alu_z;
    end

    // Response capture in EXEC; illegal codes return a zeroed payload with err
    always_comb begin
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        if ((state_q == ST_EXEC) && is_legal_ctrl(op_ctrl_q)) begin
            rsp_result_d = alu_result;
            rsp_flags_d  = alu_flags_s;
            rsp_err_d    = 1'b0;
        end else if (state_q == ST_EXEC) begin
            rsp_result_d = '0;
            rsp_flags_d  = 4'b0000;
            rsp_err_d    = 1'b1;
        end else begin
            rsp_err_d    = rsp_err_q;
        end
    end

    // Control, pointer and operand registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_ctrl_q <= 3'b000;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_ctrl_q <= op_ctrl_d;
        end
    end

    // Response payload registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_result_q <= '0;
            rsp_flags_q  <= 4'b0000;
            rsp_err_q    <= 1'b0;
        end else begin
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a      = op_a_q;
    assign alu_b      = op_b_q;
    assign alu_ctrl   = op_ctrl_q;
    assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
    assign rsp1_valid = (state_q == ST_RESP) && owner_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;

`ifdef ALU_ARB_PERF_EN
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [PERF_W-1:0] perf_cnt0_q, perf_cnt1_q;

    // Saturating per-requester grant counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cnt0_q <= '0;
            perf_cnt1_q <= '0;
        end else begin
            if (accept_s && grant_s[0] && (perf_cnt0_q != PERF_MAX)) begin
                perf_cnt0_q <= perf_cnt0_q + PERF_ONE;
            end else begin
                perf_cnt0_q <= perf_cnt0_q;
            end
            if (accept_s && grant_s[1] && (perf_cnt1_q != PERF_MAX)) begin
                perf_cnt1_q <= perf_cnt1_q + PERF_ONE;
            end else begin
                perf_cnt1_q <= perf_cnt1_q;
            end
        end
    end

    assign perf_cnt0 = perf_cnt0_q;
    assign perf_cnt1 = perf_cnt1_q;
`else
    assign perf_cnt0 = '0;
    assign perf_cnt1 = '0;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU (add/sub/and/or/slt with V/C/N/Z flags) between two requesters, e.g. the integer execute path and the address-generation path.
- Accepts operations over valid/ready, drives the ALU from registered operands, captures Result and flags, and returns them over a per-requester valid/ready response channel.
- Uses round-robin arbitration, with one operation in flight at a time.

Parameters:
- N, 32, operand/result width; the ALU sign bit is bit N-1.
- PERF_W, 16, width of the optional grant counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  N  operands
- req0_ctrl  in  3  ALU control code
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl  same as requester 0, for requester 1
- alu_a, alu_b  out  N  operands to the ALU
- alu_ctrl  out  3  ALU control to the ALU
- alu_result  in  N  ALU Result
- alu_v, alu_c, alu_n, alu_z  in  1 each  ALU flags
- rsp0_valid  out  1  response for requester 0
- rsp0_ready  in  1  requester 0 takes the response
- rsp1_valid  out  1  response for requester 1
- rsp1_ready  in  1  requester 1 takes the response
- rsp_result  out  N  captured result, shared by both response channels
- rsp_flags  out  4  captured {V,C,N,Z}
- rsp_err  out  1  operation carried an illegal ctrl code
- perf_cnt0, perf_cnt1  out  PERF_W each  grant counters (optional feature)

Behaviour:
- Legal ctrl codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT. Codes 100, 110 and 111 are illegal.
- FSM states and transitions:
  - IDLE -> EXEC when any reqX_valid is high.
  - EXEC -> RESP unconditionally.
  - RESP -> IDLE when rsp{owner}_ready is high; otherwise hold in RESP.
- IDLE grant:
  - If only one requester is valid, it wins.
  - If both are valid, the one indicated by the priority pointer wins.
  - reqX_ready is combinational and is high only in IDLE, for the winner.
  - On that edge: operands and ctrl are latched into op registers, owner is latched, and the pointer moves to the other requester.
- ready/valid rules:
  - reqX_ready is never high outside IDLE.
  - A requester must hold valid and its payload stable until ready.
- ALU drive: alu_a, alu_b and alu_ctrl always come from the op registers.
- EXEC capture:
  - alu_result and the flags are sampled into the response registers.
  - If ctrl is illegal: rsp_result = 0, rsp_flags = 0000, rsp_err = 1.
- RESP: rsp{owner}_valid is high. Payload is stable until the handshake completes. The other rsp valid is low.
- Latency and throughput:
  - Accept on edge t; rsp valid from t+2.
  - Minimum 3 cycles per operation with rsp_ready held high.
- Back-to-back: after the RESP handshake, the FSM returns to IDLE for at least one cycle before the next grant. This gives strict alternation when both requesters keep valid high.
- Simultaneous events: a new request that arrives during EXEC or RESP waits; it is neither dropped nor reordered.
- Reset values (asserted at any time, including mid-operation):
  - State IDLE, pointer = requester 0.
  - op registers, rsp_result, rsp_flags and rsp_err = 0.
  - All ready and valid outputs low; alu_ctrl = 000.
  - An in-flight operation is discarded with no response.

Optional Feature:
- Macro ALU_ARB_PERF_EN.
- Defined: perf_cnt0 and perf_cnt1 each increment on a grant to their requester. They saturate at all-ones and reset to 0.
- Undefined: the counters are not built and perf_cnt0/perf_cnt1 are tied to 0. All other behaviour is identical.

Decomposition:
- Package alu_arb_pkg holds:
  - FSM state encoding: IDLE, EXEC, RESP.
  - ALU control constants: ADD, SUB, AND, OR, SLT.
  - A legal-code check function.
  - Flag bit indices: V=3, C=2, N=1, Z=0.
- Sub-module rr_arb2: 2-way round-robin picker with inputs valid[1:0], pointer and advance; outputs one-hot grant and the next pointer.

Test Plan:
1. After reset, req0 ADD a=5, b=7 -> req0_ready in cycle 0; rsp0_valid at +2 with result 12, flags 0000, err 0.
2. req1 SUB a=3, b=3 -> result 0, Z=1, C=1. Then SLT a=-1, b=1 -> result 1.
3. ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, V=1, N=1, C=0.
4. Both requesters valid continuously with rsp_ready high -> grants alternate 0,1,0,1, one grant every 3 cycles.
5. rsp0_ready held low for 5 cycles -> rsp0_valid and payload stable, req1_ready stays 0; release -> IDLE next cycle, then req1 granted.
6. Illegal ctrl 110 -> rsp_err = 1, result 0. Assert reset during EXEC -> no response, all outputs zero, the next grant goes to req0. With ALU_ARB_PERF_EN, perf_cnt0 counts grants and saturates at 0xFFFF.
